fwd_hazard_unit: RTL and testbench

- Next-generation operand forwarding and pipeline-control block for the 5-stage Y86 pipeline, located in decode.
- Forwards any number of decode source operands from the E/M/W taps with explicit priority, and never matches RNONE.
- Detects load/use hazards, sequences ret bubbles with an internal FSM, and handles branch mispredict squash.
- Keeps saturating performance counters for forwarding and stall cycles.

---
 rtl/fwd_hazard_unit_pkg.sv | 26 ++
 rtl/fwd_hazard_unit_if.sv | 30 +++
 rtl/fwd_hazard_unit_fwd_mux.sv | 31 +++
 rtl/fwd_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the Y86 decode-stage forwarding/hazard unit.
package fwd_hazard_unit_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] RNONE_ID = 8'hF;

    // icodes the upstream stages decode into E_is_load
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_JXX    = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_R1   = 2'd1,
        ST_R2   = 2'd2,
        ST_R3   = 2'd3
    } ret_state_e;

    function automatic logic is_load_icode(input logic [3:0] icode);
        return (icode == I_MRMOVL) || (icode == I_POPL);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle: forwarding taps, hazard inputs, control and counter outputs.
interface fwd_hazard_unit_if #(
    parameter int unsigned DATA_W  = fwd_hazard_unit_pkg::WORD_W,
    parameter int unsigned REG_W   = fwd_hazard_unit_pkg::BYTE_W,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) ();
    logic [NUM_SRC*REG_W-1:0]  d_src;
    logic [NUM_SRC*DATA_W-1:0] d_rval;
    logic [REG_W-1:0]          e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, E_dstM;
    logic [DATA_W-1:0]         e_valE, m_valM, M_valE, W_valM, W_valE;
    logic                      E_is_load, D_is_ret, mispredict, clr_cnt;
    logic [NUM_SRC*DATA_W-1:0] d_val;
    logic                      F_stall, D_stall, D_bubble, E_bubble;
    logic [CNT_W-1:0]          fwd_cnt, stall_cnt;

    modport master (
        output d_src, d_rval, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
               W_dstM, W_valM, W_dstE, W_valE, E_dstM, E_is_load, D_is_ret,
               mispredict, clr_cnt,
        input  d_val, F_stall, D_stall, D_bubble, E_bubble, fwd_cnt, stall_cnt
    );

    modport slave (
        input  d_src, d_rval, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
               W_dstM, W_valM, W_dstE, W_valE, E_dstM, E_is_load, D_is_ret,
               mispredict, clr_cnt,
        output d_val, F_stall, D_stall, D_bubble, E_bubble, fwd_cnt, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_fwd_mux.sv
// Per-operand 5-tap priority forwarding select; tap 0 has the highest priority.
module fwd_mux
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned      DATA_W = WORD_W,
    parameter int unsigned      REG_W  = BYTE_W,
    parameter logic [REG_W-1:0] RNONE  = REG_W'(RNONE_ID)
) (
    input  logic [REG_W-1:0]       src_i,
    input  logic [DATA_W-1:0]      rval_i,
    input  logic [4:0][REG_W-1:0]  tap_dst_i,
    input  logic [4:0][DATA_W-1:0] tap_val_i,
    output logic [DATA_W-1:0]      val_o,
    output logic                   hit_o
);

    // A tap with dst==RNONE can never match because src==RNONE is excluded first.
    always_comb begin
        val_o = rval_i;
        hit_o = 1'b0;
        if (src_i != RNONE) begin
            for (int unsigned t = 0; t < 5; t++) begin
                if (!hit_o && (tap_dst_i[t] == src_i)) begin
                    val_o = tap_val_i[t];
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding, load/use and ret hazard control, mispredict squash,
// plus saturating forward/stall cycle counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned      DATA_W  = WORD_W,
    parameter int unsigned      REG_W   = BYTE_W,
    parameter int unsigned      NUM_SRC = 2,
    parameter logic [REG_W-1:0] RNONE   = REG_W'(RNONE_ID),
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);

    logic [4:0][REG_W-1:0]  tap_dst;
    logic [4:0][DATA_W-1:0] tap_val;
    logic [DATA_W-1:0]      val_w [NUM_SRC];
    logic [NUM_SRC-1:0]     hit;

    assign tap_dst = {bus.W_dstE, bus.W_dstM, bus.M_dstE, bus.M_dstM, bus.e_dstE};
    assign tap_val = {bus.W_valE, bus.W_valM, bus.M_valE, bus.m_valM, bus.e_valE};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_port
        fwd_mux #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W),
            .RNONE  (RNONE)
        ) u_mux (
            .src_i     (bus.d_src[g*REG_W +: REG_W]),
            .rval_i    (bus.d_rval[g*DATA_W +: DATA_W]),
            .tap_dst_i (tap_dst),
            .tap_val_i (tap_val),
            .val_o     (val_w[g]),
            .hit_o     (hit[g])
        );
    end

    always_comb begin
        bus.d_val = '0;
        for (int unsigned p = 0; p < NUM_SRC; p++) begin
            bus.d_val[p*DATA_W +: DATA_W] = val_w[p];
        end
    end

    logic lu;

    always_comb begin
        lu = 1'b0;
        for (int unsigned p = 0; p < NUM_SRC; p++) begin
            if (bus.E_is_load && (bus.E_dstM != RNONE) &&
                (bus.d_src[p*REG_W +: REG_W] != RNONE) &&
                (bus.d_src[p*REG_W +: REG_W] == bus.E_dstM)) begin
                lu = 1'b1;
            end
        end
    end

    ret_state_e state_q, state_d;
    logic       f_stall, d_stall, d_bubble, e_bubble;

    // Priority: mispredict squash, then load/use (FSM frozen), then ret sequencing.
    always_comb begin
        state_d  = state_q;
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        if (bus.mispredict) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            state_d  = ST_IDLE;
        end else if (lu) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.D_is_ret) begin
                        f_stall  = 1'b1;
                        d_bubble = 1'b1;
                        state_d  = ST_R1;
                    end
                end
                ST_R1: begin
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    state_d  = ST_R2;
                end
                ST_R2: begin
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    state_d  = ST_R3;
                end
                ST_R3: begin
                    f_stall  = 1'b1;
                    d_bubble = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.F_stall  = f_stall;
    assign bus.D_stall  = d_stall;
    assign bus.D_bubble = d_bubble;
    assign bus.E_bubble = e_bubble;

    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.clr_cnt) begin
            fwd_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if ((|hit) && (fwd_cnt_q != '1)) begin
                fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
            end
            if (f_stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_cnt   = fwd_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load/use, ret FSM, squash, counters.
module tb_fwd_hazard_unit;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 8;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned CNT_W   = 4;
    localparam logic [REG_W-1:0] RN = 8'h0F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) bus ();

    fwd_hazard_unit #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .NUM_SRC (NUM_SRC),
        .RNONE   (RN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ctrl();
        return {28'd0, bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble};
    endfunction

    task automatic clear_taps();
        bus.e_dstE = RN; bus.M_dstM = RN; bus.M_dstE = RN;
        bus.W_dstM = RN; bus.W_dstE = RN;
    endtask

    // ctrl() packing: {F_stall, D_stall, D_bubble, E_bubble}
    initial begin
        bus.d_src      = {RN, RN};
        bus.d_rval     = {32'h0000_BBBB, 32'hAAAA_0000};
        bus.e_valE     = 32'h11; bus.m_valM = 32'h33; bus.M_valE = 32'h22;
        bus.W_valM     = 32'h55; bus.W_valE = 32'h66;
        clear_taps();
        bus.E_dstM     = RN;
        bus.E_is_load  = 1'b0;
        bus.D_is_ret   = 1'b0;
        bus.mispredict = 1'b0;
        bus.clr_cnt    = 1'b0;

        #2;
        chk("reset_ctrl", ctrl(), 32'h0);
        chk("reset_fwd_cnt", 32'(bus.fwd_cnt), 32'd0);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        #1 rst = 1'b1;
        tick();

        // forwarding priority
        bus.d_src  = {RN, 8'd3};
        bus.e_dstE = 8'd3; bus.M_dstE = 8'd3;
        #1 chk("fwd_e_over_M", bus.d_val[31:0], 32'h11);
        chk("fwd_port1_rval", bus.d_val[63:32], 32'h0000_BBBB);
        tick();
        chk("fwd_cnt_1", 32'(bus.fwd_cnt), 32'd1);
        bus.e_dstE = RN;
        #1 chk("fwd_M_dstE", bus.d_val[31:0], 32'h22);
        tick();
        chk("fwd_cnt_2", 32'(bus.fwd_cnt), 32'd2);
        bus.d_src = {RN, RN};
        #1 chk("src_rnone_rval", bus.d_val[31:0], 32'hAAAA_0000);
        tick();
        chk("fwd_cnt_no_inc", 32'(bus.fwd_cnt), 32'd2);
        clear_taps();
        bus.d_src  = {8'd5, RN};
        bus.W_dstM = 8'd5; bus.W_dstE = 8'd5;
        #1 chk("fwd_WM_over_WE", bus.d_val[63:32], 32'h55);
        tick();
        chk("fwd_cnt_3", 32'(bus.fwd_cnt), 32'd3);
        clear_taps();
        bus.d_src = {RN, RN};
        tick();

        // load/use on port 1
        bus.E_is_load = 1'b1; bus.E_dstM = 8'd2; bus.d_src = {8'd2, RN};
        #1 chk("lu_ctrl", ctrl(), 32'hD);
        tick();
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.E_is_load = 1'b0;
        #1 chk("no_load_ctrl", ctrl(), 32'h0);
        chk("no_lu_fwd_cnt", 32'(bus.fwd_cnt), 32'd3);
        tick();

        // ret: four bubble cycles
        bus.D_is_ret = 1'b1;
        #1 chk("ret_c0", ctrl(), 32'hA);
        tick();
        bus.D_is_ret = 1'b0;
        #1 chk("ret_R1", ctrl(), 32'hA);
        tick(); chk("ret_R2", ctrl(), 32'hA);
        tick(); chk("ret_R3", ctrl(), 32'hA);
        tick(); chk("ret_done", ctrl(), 32'h0);
        chk("ret_stall_cnt", 32'(bus.stall_cnt), 32'd5);

        // load/use coincident with ret
        bus.E_is_load = 1'b1; bus.D_is_ret = 1'b1;
        #1 chk("lu_ret_stall", ctrl(), 32'hD);
        tick();
        bus.E_is_load = 1'b0;
        #1 chk("lu_ret_c0", ctrl(), 32'hA);
        tick();
        bus.D_is_ret = 1'b0;
        #1 chk("lu_ret_R1", ctrl(), 32'hA);
        tick(); chk("lu_ret_R2", ctrl(), 32'hA);
        tick(); chk("lu_ret_R3", ctrl(), 32'hA);
        tick(); chk("lu_ret_done", ctrl(), 32'h0);
        chk("lu_ret_stall_cnt", 32'(bus.stall_cnt), 32'd10);

        // mispredict during R2
        bus.D_is_ret = 1'b1;
        #1 chk("mp_c0", ctrl(), 32'hA);
        tick();
        bus.D_is_ret = 1'b0;
        tick();
        bus.mispredict = 1'b1;
        #1 chk("mp_in_R2", ctrl(), 32'h3);
        tick();
        bus.mispredict = 1'b0;
        #1 chk("mp_idle_1", ctrl(), 32'h0);
        tick(); chk("mp_idle_2", ctrl(), 32'h0);
        chk("mp_stall_cnt", 32'(bus.stall_cnt), 32'd12);

        // simultaneous mispredict and ret
        bus.mispredict = 1'b1; bus.D_is_ret = 1'b1;
        #1 chk("mp_ret_same", ctrl(), 32'h3);
        tick();
        bus.mispredict = 1'b0; bus.D_is_ret = 1'b0;
        #1 chk("mp_ret_no_fsm", ctrl(), 32'h0);
        chk("mp_ret_stall_cnt", 32'(bus.stall_cnt), 32'd12);

        // saturation and clear
        bus.E_is_load = 1'b1;
        repeat (6) tick();
        chk("stall_sat", 32'(bus.stall_cnt), 32'd15);
        bus.E_is_load = 1'b0; bus.clr_cnt = 1'b1;
        tick();
        chk("clr_stall", 32'(bus.stall_cnt), 32'd0);
        chk("clr_fwd", 32'(bus.fwd_cnt), 32'd0);
        bus.E_is_load = 1'b1;
        tick();
        chk("clr_beats_inc", 32'(bus.stall_cnt), 32'd0);
        bus.E_is_load = 1'b0; bus.clr_cnt = 1'b0;
        bus.d_src = {RN, 8'd3}; bus.e_dstE = 8'd3;
        repeat (17) tick();
        chk("fwd_sat", 32'(bus.fwd_cnt), 32'd15);
        clear_taps();
        bus.d_src = {RN, RN};
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk("clr_fwd_sat", 32'(bus.fwd_cnt), 32'd0);

        // reset asserted mid-R1
        bus.D_is_ret = 1'b1;
        tick();
        bus.D_is_ret = 1'b0;
        #1 chk("pre_rst_R1", ctrl(), 32'hA);
        rst = 1'b0;
        #1 chk("rst_ctrl", ctrl(), 32'h0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_ctrl", ctrl(), 32'h0);
        chk("post_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
